hpdcache_mem_refill_serializer: RTL and testbench

- Memory-side transmitter for the HPDcache refill interface: the end that produces the refill responses the cache's refill FIFO consumes.
- Accepts whole cache-line responses from the L1.5/NoC adapter and buffers them in a small line FIFO.
- Sends each line to the HPDcache memory-response port as CL_WORDS/BEAT_WORDS beats, each carrying the transaction ID, the error flag and a last marker.

---
 rtl/hpdcache_mem_refill_serializer.sv | 117 +++++++++++
 tb/tb_hpdcache_mem_refill_serializer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hpdcache_mem_refill_serializer.sv
// hpdcache_mem_refill_serializer: buffers whole refill lines and streams them to the HPDcache as beats
module hpdcache_mem_refill_serializer #(
  parameter int WORD_WIDTH = 64,
  parameter int CL_WORDS   = 8,
  parameter int BEAT_WORDS = 4,
  parameter int ID_WIDTH   = 7,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                line_valid_i,
  output logic                                line_ready_o,
  input  logic [CL_WORDS*WORD_WIDTH-1:0]      line_data_i,
  input  logic [ID_WIDTH-1:0]                 line_id_i,
  input  logic                                line_error_i,
  output logic                                rsp_valid_o,
  input  logic                                rsp_ready_i,
  output logic [BEAT_WORDS*WORD_WIDTH-1:0]    rsp_data_o,
  output logic [ID_WIDTH-1:0]                 rsp_id_o,
  output logic                                rsp_error_o,
  output logic                                rsp_last_o,
  output logic                                busy_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     occupancy_o
);
  localparam int BEATS  = CL_WORDS / BEAT_WORDS;
  localparam int CNT_W  = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int PTR_W  = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W  = $clog2(FIFO_DEPTH + 1);
  localparam int LINE_W = CL_WORDS * WORD_WIDTH;
  localparam int BEAT_W = BEAT_WORDS * WORD_WIDTH;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  if ((CL_WORDS % BEAT_WORDS) != 0 || FIFO_DEPTH < 1) begin : g_param_check
    $error("hpdcache_mem_refill_serializer: BEAT_WORDS must divide CL_WORDS and FIFO_DEPTH must be >= 1");
  end

  typedef enum logic {IDLE, SEND} state_t;

  state_t                   state, state_next;
  logic [LINE_W-1:0]        mem_data [FIFO_DEPTH];
  logic [ID_WIDTH-1:0]      mem_id   [FIFO_DEPTH];
  logic                     mem_err  [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr, rd_ptr;
  logic [OCC_W-1:0]         count, count_next;
  logic [CNT_W-1:0]         beat_cnt;
  logic [LINE_W-1:0]        head_data;
  logic                     push, pop, hs;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign line_ready_o = count != OCC_W'(FIFO_DEPTH);
  assign push         = line_valid_i && line_ready_o;
  assign rsp_valid_o  = state == SEND;
  assign hs           = rsp_valid_o && rsp_ready_i;
  assign pop          = hs && beat_cnt == LAST_BEAT;
  assign count_next   = count + OCC_W'(push) - OCC_W'(pop);
  assign busy_o       = count != '0;
  assign occupancy_o  = count;

  // Outputs are gated by valid so they read as zero whenever nothing is presented, including in reset.
  assign head_data   = mem_data[rd_ptr];
  assign rsp_data_o  = rsp_valid_o ? head_data[int'(beat_cnt)*BEAT_W +: BEAT_W] : '0;
  assign rsp_id_o    = rsp_valid_o ? mem_id[rd_ptr] : '0;
  assign rsp_error_o = rsp_valid_o && mem_err[rd_ptr];
  assign rsp_last_o  = rsp_valid_o && beat_cnt == LAST_BEAT;

  // Line storage; contents need no reset because every output is masked while idle.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_data[wr_ptr] <= line_data_i;
      mem_id[wr_ptr]   <= line_id_i;
      mem_err[wr_ptr]  <= line_error_i;
    end
  end

  // FIFO pointers, occupancy, beat position and FSM state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_next;
      count    <= count_next;
      wr_ptr   <= push ? ptr_inc(wr_ptr) : wr_ptr;
      rd_ptr   <= pop ? ptr_inc(rd_ptr) : rd_ptr;
      beat_cnt <= pop ? '0 : hs ? beat_cnt + 1'b1 : beat_cnt;
    end
  end

  // Next state: a new line starts sending the cycle after acceptance; keep sending while lines remain.
  always_comb begin
    state_next = state;
    if (state == IDLE) state_next = push ? SEND : IDLE;
    else state_next = (pop && count_next == '0) ? IDLE : SEND;
  end

  logic [CNT_W-1:0] mon_cnt;

  // Independent count of beats handed over since the last final beat.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) mon_cnt <= '0;
    else if (hs) mon_cnt <= rsp_last_o ? '0 : mon_cnt + 1'b1;
  end

  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push && count == OCC_W'(FIFO_DEPTH)));
  a_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (rsp_valid_o && !rsp_ready_i) |=> (rsp_valid_o && $stable(rsp_data_o) && $stable(rsp_id_o)
      && $stable(rsp_error_o) && $stable(rsp_last_o)));
  a_beats: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (hs && rsp_last_o) |-> mon_cnt == LAST_BEAT);
endmodule

// File: tb/tb_hpdcache_mem_refill_serializer.sv
// tb_hpdcache_mem_refill_serializer: directed and scoreboarded checks of the refill serializer
module tb_hpdcache_mem_refill_serializer;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;

  logic l_valid, l_ready, l_err, r_valid, r_ready, r_err, r_last, busy;
  logic [511:0] l_data;
  logic [6:0]   l_id, r_id;
  logic [255:0] r_data;
  logic [1:0]   occ;

  logic l_valid1, l_ready1, l_err1, r_valid1, r_ready1, r_err1, r_last1, busy1;
  logic [511:0] l_data1, r_data1;
  logic [6:0]   l_id1, r_id1;
  logic [2:0]   occ1;

  int vectors = 0, miscompares = 0;

  hpdcache_mem_refill_serializer u_dut (
    .clk_i(clk), .rst_ni(rst_n), .line_valid_i(l_valid), .line_ready_o(l_ready),
    .line_data_i(l_data), .line_id_i(l_id), .line_error_i(l_err), .rsp_valid_o(r_valid),
    .rsp_ready_i(r_ready), .rsp_data_o(r_data), .rsp_id_o(r_id), .rsp_error_o(r_err),
    .rsp_last_o(r_last), .busy_o(busy), .occupancy_o(occ));

  hpdcache_mem_refill_serializer #(.BEAT_WORDS(8), .FIFO_DEPTH(4)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .line_valid_i(l_valid1), .line_ready_o(l_ready1),
    .line_data_i(l_data1), .line_id_i(l_id1), .line_error_i(l_err1), .rsp_valid_o(r_valid1),
    .rsp_ready_i(r_ready1), .rsp_data_o(r_data1), .rsp_id_o(r_id1), .rsp_error_o(r_err1),
    .rsp_last_o(r_last1), .busy_o(busy1), .occupancy_o(occ1));

  function automatic logic [511:0] mk(input logic [63:0] base);
    logic [511:0] l;
    for (int i = 0; i < 8; i++) l[i*64 +: 64] = base + 64'(i);
    return l;
  endfunction

  task automatic test_reset;
    #2;
    vectors++;
    if ({r_valid, l_ready, busy, occ, r_last, r_id, r_err, r_data} !== {1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 7'd0, 1'b0, 256'd0}) begin
      miscompares++; $display("FAIL reset_dut0: got %h want all zero with line_ready=1", {r_valid, l_ready, busy, occ, r_last, r_id, r_err});
    end
    vectors++;
    if ({r_valid1, l_ready1, busy1, occ1, r_last1} !== {1'b0, 1'b1, 1'b0, 3'd0, 1'b0}) begin
      miscompares++; $display("FAIL reset_dut1: got %b want 0100000", {r_valid1, l_ready1, busy1, occ1, r_last1});
    end
    @(posedge clk); @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_single;
    logic [511:0] ln = mk(64'h10);
    r_ready = 1; l_valid = 1; l_data = ln; l_id = 7'h15; l_err = 0;
    @(posedge clk); #1 l_valid = 0;
    vectors++;
    if ({r_valid, r_last, r_id, r_data} !== {1'b1, 1'b0, 7'h15, ln[255:0]}) begin
      miscompares++; $display("FAIL single_beat0: got %h want %h", {r_valid, r_last, r_id, r_data}, {1'b1, 1'b0, 7'h15, ln[255:0]});
    end
    @(posedge clk); #1;
    vectors++;
    if ({r_valid, r_last, r_id, r_data} !== {1'b1, 1'b1, 7'h15, ln[511:256]}) begin
      miscompares++; $display("FAIL single_beat1: got %h want %h", {r_valid, r_last, r_id, r_data}, {1'b1, 1'b1, 7'h15, ln[511:256]});
    end
    @(posedge clk); #1;
    vectors++;
    if ({r_valid, busy, r_data} !== {1'b0, 1'b0, 256'd0}) begin
      miscompares++; $display("FAIL single_idle: got valid=%b busy=%b want 0 0", r_valid, busy);
    end
  endtask

  task automatic test_backpressure;
    logic [511:0] a = mk(64'h20), b = mk(64'h30), c = mk(64'h40);
    logic [266:0] got;
    logic [266:0] exp [6];
    exp[0] = {1'b0, 1'b1, 1'b0, 7'd1, a[255:0]};
    exp[1] = {1'b0, 1'b1, 1'b1, 7'd1, a[511:256]};
    exp[2] = {1'b1, 1'b1, 1'b0, 7'd2, b[255:0]};
    exp[3] = {1'b0, 1'b1, 1'b1, 7'd2, b[511:256]};
    exp[4] = {1'b1, 1'b1, 1'b0, 7'd3, c[255:0]};
    exp[5] = {1'b1, 1'b1, 1'b1, 7'd3, c[511:256]};
    r_ready = 0; l_valid = 1; l_data = a; l_id = 7'd1;
    @(posedge clk); #1;
    vectors++;
    if ({l_ready, occ} !== {1'b1, 2'd1}) begin
      miscompares++; $display("FAIL bp_first_accept: got ready,occ=%b want 101", {l_ready, occ});
    end
    l_data = b; l_id = 7'd2;
    @(posedge clk); #1;
    vectors++;
    if ({l_ready, occ, busy} !== {1'b0, 2'd2, 1'b1}) begin
      miscompares++; $display("FAIL bp_full: got ready,occ,busy=%b want 0101", {l_ready, occ, busy});
    end
    l_data = c; l_id = 7'd3; r_ready = 1;
    for (int k = 0; k < 6; k++) begin
      if (k == 3) l_valid = 0;
      got = {l_ready, r_valid, r_last, r_id, r_data};
      vectors++;
      if (got !== exp[k]) begin
        miscompares++; $display("FAIL bp_beat%0d: got %h want %h", k, got, exp[k]);
      end
      @(posedge clk); #1;
    end
    vectors++;
    if ({r_valid, busy, occ} !== 4'b0000) begin
      miscompares++; $display("FAIL bp_idle: got valid,busy,occ=%b want 0000", {r_valid, busy, occ});
    end
  endtask

  task automatic test_push_pop;
    logic [511:0] g = mk(64'h80), h = mk(64'h90);
    r_ready = 1; l_valid = 1; l_data = g; l_id = 7'd8; l_err = 0;
    @(posedge clk); #1 l_valid = 0;
    @(posedge clk); #1;
    l_valid = 1; l_data = h; l_id = 7'd9; l_err = 1;
    vectors++;
    if ({occ, r_valid, r_last, r_id, r_data} !== {2'd1, 1'b1, 1'b1, 7'd8, g[511:256]}) begin
      miscompares++; $display("FAIL pp_last_beat: got %h want %h", {occ, r_valid, r_last, r_id, r_data}, {2'd1, 1'b1, 1'b1, 7'd8, g[511:256]});
    end
    @(posedge clk); #1 l_valid = 0; l_err = 0;
    vectors++;
    if ({occ, r_valid, r_last, r_err, r_id, r_data} !== {2'd1, 1'b1, 1'b0, 1'b1, 7'd9, h[255:0]}) begin
      miscompares++; $display("FAIL pp_next_beat0: got %h want %h", {occ, r_valid, r_last, r_err, r_id, r_data}, {2'd1, 1'b1, 1'b0, 1'b1, 7'd9, h[255:0]});
    end
    @(posedge clk); #1;
    vectors++;
    if ({r_valid, r_last, r_err, r_data} !== {1'b1, 1'b1, 1'b1, h[511:256]}) begin
      miscompares++; $display("FAIL pp_next_beat1: got %h want %h", {r_valid, r_last, r_err, r_data}, {1'b1, 1'b1, 1'b1, h[511:256]});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    logic [511:0] q_data[$];
    logic [6:0]   q_id[$];
    logic         q_err[$];
    int beats = 0;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          logic [511:0] ln;
          logic acc = 0;
          int n = 0;
          for (int j = 0; j < 16; j++) ln[j*32 +: 32] = $urandom;
          l_valid = 1; l_data = ln; l_id = 7'(i); l_err = ((i + 1) % 7) == 0;
          while (!acc && n < 100) begin
            acc = l_ready; @(posedge clk); #1; n++;
          end
          vectors++;
          if (acc) begin
            q_data.push_back(ln); q_id.push_back(7'(i)); q_err.push_back(((i + 1) % 7) == 0);
          end else begin
            miscompares++; $display("FAIL rnd_accept line %0d: got no acceptance within 100 cycles want accept", i);
          end
        end
        l_valid = 0; l_err = 0;
      end
      begin
        int bi = 0, cyc = 0;
        logic stalled = 0;
        logic [265:0] prev = '0, cur;
        logic [511:0] hd;
        while (beats < 200 && cyc < 5000) begin
          @(posedge clk); #1 r_ready = 1'($urandom_range(0, 1));
          @(negedge clk); cyc++;
          cur = {r_valid, r_data, r_id, r_err, r_last};
          if (stalled) begin
            vectors++;
            if (cur !== prev) begin
              miscompares++; $display("FAIL rnd_stall_hold: got %h want %h", cur, prev);
            end
          end
          if (r_valid) begin
            vectors++;
            if (q_data.size() == 0) begin
              miscompares++; $display("FAIL rnd_unexpected_beat: got valid=1 want no beat (scoreboard empty)");
            end else begin
              hd = q_data[0];
              if ({r_data, r_id, r_err, r_last} !== {hd[bi*256 +: 256], q_id[0], q_err[0], bi == 1}) begin
                miscompares++; $display("FAIL rnd_beat id %0d beat %0d: got %h want %h", q_id[0], bi,
                  {r_data, r_id, r_err, r_last}, {hd[bi*256 +: 256], q_id[0], q_err[0], bi == 1});
              end
              if (r_ready) begin
                beats++;
                if (bi == 1) begin
                  bi = 0; void'(q_data.pop_front()); void'(q_id.pop_front()); void'(q_err.pop_front());
                end else bi = 1;
              end
            end
          end
          stalled = r_valid && !r_ready;
          prev = cur;
        end
      end
    join
    vectors++;
    if (beats != 200) begin
      miscompares++; $display("FAIL rnd_beat_count: got %0d want 200", beats);
    end
    r_ready = 1;
    @(posedge clk); #1; @(posedge clk); #1;
    vectors++;
    if ({busy, r_valid} !== 2'b00) begin
      miscompares++; $display("FAIL rnd_drain: got busy,valid=%b want 00", {busy, r_valid});
    end
  endtask

  task automatic test_beats1;
    logic [511:0] ln;
    r_ready1 = 0; l_err1 = 0;
    for (int k = 0; k < 4; k++) begin
      l_valid1 = 1; l_data1 = mk(64'(256 * k + 7)); l_id1 = 7'(k + 40);
      @(posedge clk); #1;
    end
    l_valid1 = 0;
    vectors++;
    if ({occ1, l_ready1, busy1, r_valid1} !== {3'd4, 1'b0, 1'b1, 1'b1}) begin
      miscompares++; $display("FAIL b1_full: got occ,ready,busy,valid=%b want 100011", {occ1, l_ready1, busy1, r_valid1});
    end
    r_ready1 = 1;
    for (int k = 0; k < 4; k++) begin
      ln = mk(64'(256 * k + 7));
      vectors++;
      if ({r_valid1, r_last1, r_id1, r_data1} !== {1'b1, 1'b1, 7'(k + 40), ln}) begin
        miscompares++; $display("FAIL b1_line%0d: got %h want %h", k, {r_valid1, r_last1, r_id1, r_data1}, {1'b1, 1'b1, 7'(k + 40), ln});
      end
      @(posedge clk); #1;
    end
    vectors++;
    if ({r_valid1, busy1, occ1} !== 5'b00000) begin
      miscompares++; $display("FAIL b1_idle: got valid,busy,occ=%b want 00000", {r_valid1, busy1, occ1});
    end
    r_ready1 = 0;
  endtask

  task automatic test_reset_mid;
    logic [511:0] d = mk(64'h50), f = mk(64'h70);
    r_ready = 1; l_valid = 1; l_data = d; l_id = 7'd5; l_err = 1;
    @(posedge clk); #1 l_data = mk(64'h60); l_id = 7'd6; l_err = 0;
    @(posedge clk); #1 l_valid = 0;
    vectors++;
    if ({occ, r_valid, r_last, r_data} !== {2'd2, 1'b1, 1'b1, d[511:256]}) begin
      miscompares++; $display("FAIL rm_pre: got %h want %h", {occ, r_valid, r_last, r_data}, {2'd2, 1'b1, 1'b1, d[511:256]});
    end
    rst_n = 0;
    #1;
    vectors++;
    if ({r_valid, l_ready, busy, occ, r_last, r_id, r_err, r_data} !== {1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 7'd0, 1'b0, 256'd0}) begin
      miscompares++; $display("FAIL rm_async: got %h want zero outputs with line_ready=1", {r_valid, l_ready, busy, occ, r_last, r_id, r_err});
    end
    @(posedge clk); #1 rst_n = 1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      vectors++;
      if ({r_valid, occ, busy} !== 4'b0000) begin
        miscompares++; $display("FAIL rm_quiet%0d: got valid,occ,busy=%b want 0000", k, {r_valid, occ, busy});
      end
    end
    l_valid = 1; l_data = f; l_id = 7'd7;
    @(posedge clk); #1 l_valid = 0;
    vectors++;
    if ({r_valid, r_last, r_id, r_data} !== {1'b1, 1'b0, 7'd7, f[255:0]}) begin
      miscompares++; $display("FAIL rm_new_line: got %h want %h", {r_valid, r_last, r_id, r_data}, {1'b1, 1'b0, 7'd7, f[255:0]});
    end
    @(posedge clk); #1; @(posedge clk); #1;
  endtask

  initial begin
    l_valid = 0; l_data = '0; l_id = '0; l_err = 0; r_ready = 0;
    l_valid1 = 0; l_data1 = '0; l_id1 = '0; l_err1 = 0; r_ready1 = 0;
    test_reset;
    test_single;
    test_backpressure;
    test_push_pop;
    test_random;
    test_beats1;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
